// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the data-memory port arbiter:
// the per-requester beat payload, lock-owner encoding and requester count.
package riscv_pkg;

    localparam int unsigned DmemXlen   = 32;
    localparam int unsigned DmemNumReq = 3;

    // One memory beat as presented by a requester.
    typedef struct packed {
        logic [DmemXlen-1:0] addr;
        logic [DmemXlen-1:0] wdata;
        logic [3:0]          be;
        logic                lock;
    } dmem_req_t;

    // Lock owner; the encoding is also the externally visible o_owner value.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_AMO  = 2'd1,
        OWN_FP   = 2'd2,
        OWN_PIPE = 2'd3
    } dmem_owner_e;

endpackage

// File: rtl/dmem_lock_counter.sv
// Saturating count of consecutive locked cycles. cnt_q holds the number of
// locked cycles already completed, so timeout_o fires during the
// LOCK_TIMEOUT-th locked cycle, which is the cycle the lock is forcibly dropped.
module dmem_lock_counter
    import riscv_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CW-1:0] MaxCnt  = CW'(LOCK_TIMEOUT);
    localparam logic [CW-1:0] LastCnt = CW'(LOCK_TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear on lock entry, otherwise count locked cycles up to the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory BRAM port between the AMO unit, the FP64
// load/store sequencer and the pipeline load/store path. Fixed priority
// amo > fp > pipe, one beat per cycle, optional multi-beat lock with a
// timeout, and a one-cycle read-return tag per requester.
module dmem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_amo_req,
    input  logic [XLEN-1:0] i_amo_addr,
    input  logic [XLEN-1:0] i_amo_wdata,
    input  logic [3:0]      i_amo_be,
    input  logic            i_amo_lock,
    output logic            o_amo_gnt,
    output logic            o_amo_rvalid,
    input  logic            i_fp_req,
    input  logic [XLEN-1:0] i_fp_addr,
    input  logic [XLEN-1:0] i_fp_wdata,
    input  logic [3:0]      i_fp_be,
    input  logic            i_fp_lock,
    output logic            o_fp_gnt,
    output logic            o_fp_rvalid,
    input  logic            i_pipe_req,
    input  logic [XLEN-1:0] i_pipe_addr,
    input  logic [XLEN-1:0] i_pipe_wdata,
    input  logic [3:0]      i_pipe_be,
    input  logic            i_pipe_lock,
    output logic            o_pipe_gnt,
    output logic            o_pipe_rvalid,
    output logic            o_mem_en,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [3:0]      o_mem_be,
    output logic            o_stall_pipe,
    output logic            o_lock_timeout,
    output logic [1:0]      o_owner
);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    // Index 0 = amo, 1 = fp, 2 = pipe (priority order).
    dmem_req_t                 reqs [DmemNumReq];
    logic [DmemNumReq-1:0]     req_v;
    logic [DmemNumReq-1:0]     own_oh;
    logic [DmemNumReq-1:0]     gnt;
    dmem_req_t                 win;
    dmem_owner_e               gnt_owner;

    logic [0:0]                state_q, state_d;
    dmem_owner_e               owner_q, owner_d;
    logic                      rd_pend_q, rd_pend_d;
    dmem_owner_e               rd_id_q, rd_id_d;

    logic                      cnt_clr;
    logic                      lock_tmo;
    logic                      flush_brk;

    assign reqs[0] = '{addr: i_amo_addr,  wdata: i_amo_wdata,  be: i_amo_be,  lock: i_amo_lock};
    assign reqs[1] = '{addr: i_fp_addr,   wdata: i_fp_wdata,   be: i_fp_be,   lock: i_fp_lock};
    assign reqs[2] = '{addr: i_pipe_addr, wdata: i_pipe_wdata, be: i_pipe_be, lock: i_pipe_lock};
    assign req_v   = {i_pipe_req, i_fp_req, i_amo_req};

    assign own_oh  = {owner_q == OWN_PIPE, owner_q == OWN_FP, owner_q == OWN_AMO};

    // A flush abandons fp/pipe lock sequences, but an AMO must finish its write.
    assign flush_brk = i_flush && (owner_q != OWN_AMO);

    // Grant selection: fixed priority when unlocked, owner-only when locked.
    always_comb begin
        gnt = '0;
        if (state_q == ST_UNLOCKED) begin
            if (req_v[0]) begin
                gnt = 3'b001;
            end else if (req_v[1]) begin
                gnt = 3'b010;
            end else if (req_v[2] && !i_flush) begin
                gnt = 3'b100;
            end
        end else if (!lock_tmo && !flush_brk) begin
            gnt = own_oh & req_v;
        end
        // Grants drop the instant reset asserts, before any clock edge.
        if (!i_rst_n) begin
            gnt = '0;
        end
    end

    // Winner payload and owner encoding of the granted requester.
    always_comb begin
        win       = '0;
        gnt_owner = OWN_NONE;
        for (int i = 0; i < DmemNumReq; i++) begin
            if (gnt[i]) begin
                win = reqs[i];
            end
        end
        case (gnt)
            3'b001:  gnt_owner = OWN_AMO;
            3'b010:  gnt_owner = OWN_FP;
            3'b100:  gnt_owner = OWN_PIPE;
            default: gnt_owner = OWN_NONE;
        endcase
    end

    // Lock FSM next state; every release path takes effect in the current cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_clr = 1'b0;
        if (state_q == ST_UNLOCKED) begin
            if ((|gnt) && win.lock) begin
                state_d = ST_LOCKED;
                owner_d = gnt_owner;
                cnt_clr = 1'b1;
            end
        end else if (lock_tmo || flush_brk || !(|(own_oh & req_v)) || ((|gnt) && !win.lock)) begin
            state_d = ST_UNLOCKED;
            owner_d = OWN_NONE;
        end
    end

    // Read-return tracker: a granted read returns exactly one cycle later.
    always_comb begin
        rd_pend_d = (|gnt) && (win.be == 4'h0);
        rd_id_d   = gnt_owner;
    end

    // Control state registers; reset drops any lock and any pending return.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_UNLOCKED;
            owner_q   <= OWN_NONE;
            rd_pend_q <= 1'b0;
            rd_id_q   <= OWN_NONE;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    dmem_lock_counter #(
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_lock_counter (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .clr_i     (cnt_clr),
        .en_i      (state_q == ST_LOCKED),
        .timeout_o (lock_tmo)
    );

    assign o_amo_gnt      = gnt[0];
    assign o_fp_gnt       = gnt[1];
    assign o_pipe_gnt     = gnt[2];

    assign o_amo_rvalid   = rd_pend_q && (rd_id_q == OWN_AMO);
    assign o_fp_rvalid    = rd_pend_q && (rd_id_q == OWN_FP);
    assign o_pipe_rvalid  = rd_pend_q && (rd_id_q == OWN_PIPE);

    assign o_mem_en       = |gnt;
    assign o_mem_addr     = {win.addr[XLEN-1:2], 2'b00};
    assign o_mem_wdata    = win.wdata;
    assign o_mem_be       = win.be;

    assign o_stall_pipe   = i_rst_n && i_pipe_req && !gnt[2];
    assign o_lock_timeout = lock_tmo;
    assign o_owner        = owner_q;

endmodule
